// File: rtl/rf_write_queue_if.sv
// rf_write_queue_if
//   Bundles the write-queue signals: two producer request channels (A, B),
//   the drain hold control, the register-file write port, two bypass lookup
//   ports and the occupancy count.
//   master : the surrounding pipeline (drives requests, hold, lookup addresses)
//   slave  : the write queue itself (drives readies, rf_* port, hits, count)
interface rf_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          a_valid;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          a_ready;

  logic          b_valid;
  logic [AW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic          b_ready;

  logic          hold;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  logic [AW-1:0] rd_addr1;
  logic          rd_hit1;
  logic [DW-1:0] rd_data1;
  logic [AW-1:0] rd_addr2;
  logic          rd_hit2;
  logic [DW-1:0] rd_data2;

  logic [CW-1:0] count;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, hold, rd_addr1, rd_addr2,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
           rd_hit1, rd_data1, rd_hit2, rd_data2, count
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, hold, rd_addr1, rd_addr2,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
           rd_hit1, rd_data1, rd_hit2, rd_data2, count
  );
endinterface

// File: rtl/rf_write_queue.sv
// rf_write_queue
//   Write-side front end of the register file. Merges writeback requests from
//   producer A (main pipeline) and producer B (long-latency unit) into a single
//   register-file write port, one write per cycle, in arrival order. Pending
//   writes are visible to decode through two bypass lookup ports.
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : rf_write_queue_if.slave -- requests/readies, hold, rf_* write port,
//          bypass lookups and occupancy count
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  rf_write_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] regMem  [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [PW-1:0] bTail;
  logic [CW-1:0] count;
  logic          accA;
  logic          accB;
  logic          pop;
  logic [1:0]    enqCount;

  // Pointer advance with wrap at DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW+1:0] s;
    s = (PW+2)'(p) + (PW+2)'(n);
    if (s >= (PW+2)'(DEPTH)) s = s - (PW+2)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Walk valid entries oldest to newest so the newest match overwrites older
  // ones. Register 0 is never stored, but the guard keeps addr 0 from hitting.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
    logic          hit;
    logic [DW-1:0] data;
    int            j;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      j = int'(headPtr) + i;
      if (j >= DEPTH) j = j - DEPTH;
      if ((i < int'(count)) && (addr != '0) && (regMem[PW'(j)] == addr)) begin
        hit  = 1'b1;
        data = dataMem[PW'(j)];
      end
    end
    return {hit, data};
  endfunction

  // Readiness uses only the registered count: a pop in the same cycle frees
  // nothing until the next edge. B only sees what is left after A's request.
  assign bus.a_ready = (count < CW'(DEPTH));
  assign bus.b_ready = (({1'b0, count} + (CW+1)'(bus.a_valid)) < (CW+1)'(DEPTH));

  // Register-0 writes complete the handshake but never occupy a slot.
  assign accA     = bus.a_valid && bus.a_ready && (bus.a_reg != '0);
  assign accB     = bus.b_valid && bus.b_ready && (bus.b_reg != '0);
  assign enqCount = {1'b0, accA} + {1'b0, accB};
  assign bTail    = wrapAdd(tailPtr, {1'b0, accA});

  // Drain the head whenever something is pending and the port is not borrowed.
  // Because count clears asynchronously, rf_we drops the moment rst falls.
  assign pop          = (count != '0) && !bus.hold;
  assign bus.rf_we    = pop;
  assign bus.rf_waddr = (count != '0) ? regMem[headPtr]  : '0;
  assign bus.rf_wdata = (count != '0) ? dataMem[headPtr] : '0;
  assign bus.count    = count;

  assign {bus.rd_hit1, bus.rd_data1} = lookup(bus.rd_addr1);
  assign {bus.rd_hit2, bus.rd_data2} = lookup(bus.rd_addr2);

  // Occupancy and pointers; reset discards every pending entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (pop) headPtr <= wrapAdd(headPtr, 2'd1);
      tailPtr <= wrapAdd(tailPtr, enqCount);
      count   <= count + CW'(enqCount) - CW'(pop);
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever read.
  // A takes the tail slot first so it is older than a same-cycle B.
  always_ff @(posedge clk) begin
    if (accA) begin
      regMem[tailPtr]  <= bus.a_reg;
      dataMem[tailPtr] <= bus.a_data;
    end
    if (accB) begin
      regMem[bTail]  <= bus.b_reg;
      dataMem[bTail] <= bus.b_data;
    end
  end
endmodule

// File: tb/tb_rf_write_queue.sv
// tb_rf_write_queue
//   Directed testbench for rf_write_queue. Expected register-file writes are
//   queued as requests are issued; a negedge monitor compares every rf_we cycle
//   against the head of that queue. Status outputs are checked directly.
module tb_rf_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [AW+DW-1:0] expQ [$];

  rf_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  rf_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Drive one cycle of requests; expX marks requests the bench expects to be
  // accepted, and those with a nonzero register are queued as future writes.
  task automatic applyStimulus(input logic aV, input logic [AW-1:0] aR, input logic [DW-1:0] aD,
                               input logic bV, input logic [AW-1:0] bR, input logic [DW-1:0] bD,
                               input logic h, input logic expA, input logic expB);
    bus.a_valid = aV;
    bus.a_reg   = aR;
    bus.a_data  = aD;
    bus.b_valid = bV;
    bus.b_reg   = bR;
    bus.b_data  = bD;
    bus.hold    = h;
    if (expA && aV && (aR != '0)) expQ.push_back({aR, aD});
    if (expB && bV && (bR != '0)) expQ.push_back({bR, bD});
  endtask

  task automatic idle(input logic h);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, h, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 16; i++) begin
      if (bus.count == '0) break;
      @(negedge clk);
    end
    checkOutput(name, 64'(bus.count), 64'd0);
  endtask

  // Monitor: every cycle the queue writes, it must be the oldest expected write.
  always @(negedge clk) begin : monitor
    logic [AW+DW-1:0] e;
    if (rst && (bus.rf_we === 1'b1)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected write actual=%0h:%0h required=none", bus.rf_waddr, bus.rf_wdata);
      end else begin
        e = expQ.pop_front();
        checkOutput("write addr", 64'(bus.rf_waddr), 64'(e[AW+DW-1:DW]));
        checkOutput("write data", 64'(bus.rf_wdata), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    idle(1'b0);
    bus.rd_addr1 = 5'd5;
    bus.rd_addr2 = 5'd3;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("reset rf_we",    64'(bus.rf_we),    64'd0);
    checkOutput("reset count",    64'(bus.count),    64'd0);
    checkOutput("reset a_ready",  64'(bus.a_ready),  64'd1);
    checkOutput("reset b_ready",  64'(bus.b_ready),  64'd1);
    checkOutput("reset hit1",     64'(bus.rd_hit1),  64'd0);
    checkOutput("reset hit2",     64'(bus.rd_hit2),  64'd0);
    checkOutput("reset waddr",    64'(bus.rf_waddr), 64'd0);
    checkOutput("reset data1",    64'(bus.rd_data1), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single write: one cycle latency, then empty again
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t2 a_ready", 64'(bus.a_ready), 64'd1);
    nextCycle();
    idle(1'b0);
    @(negedge clk);
    checkOutput("t2 rf_we",    64'(bus.rf_we),    64'd1);
    checkOutput("t2 waddr",    64'(bus.rf_waddr), 64'd5);
    checkOutput("t2 wdata",    64'(bus.rf_wdata), 64'hDEADBEEF);
    checkOutput("t2 count",    64'(bus.count),    64'd1);
    checkOutput("t2 head hit", 64'(bus.rd_hit1),  64'd1);
    checkOutput("t2 head data",64'(bus.rd_data1), 64'hDEADBEEF);
    nextCycle();
    @(negedge clk);
    checkOutput("t2 rf_we after", 64'(bus.rf_we), 64'd0);
    checkOutput("t2 count after", 64'(bus.count), 64'd0);

    // Same-cycle A and B to the same register: B is newer and wins the bypass
    nextCycle();
    applyStimulus(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 32'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t3 a_ready", 64'(bus.a_ready), 64'd1);
    checkOutput("t3 b_ready", 64'(bus.b_ready), 64'd1);
    nextCycle();
    idle(1'b1);
    bus.rd_addr1 = 5'd3;
    bus.rd_addr2 = 5'd4;
    @(negedge clk);
    checkOutput("t3 count", 64'(bus.count),    64'd2);
    checkOutput("t3 hit1",  64'(bus.rd_hit1),  64'd1);
    checkOutput("t3 data1", 64'(bus.rd_data1), 64'd2);
    checkOutput("t3 hit2",  64'(bus.rd_hit2),  64'd0);
    checkOutput("t3 data2", 64'(bus.rd_data2), 64'd0);
    checkOutput("t3 held",  64'(bus.rf_we),    64'd0);
    nextCycle();
    idle(1'b0);
    @(negedge clk);
    checkOutput("t3 drain start", 64'(bus.rf_we), 64'd1);
    waitDrain("t3 drain count");

    // Fill under hold, check credit rules, then drain in order
    nextCycle();
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    nextCycle();
    idle(1'b1);
    @(negedge clk);
    checkOutput("t4 count3",   64'(bus.count),   64'd3);
    checkOutput("t4 a_ready3", 64'(bus.a_ready), 64'd1);
    checkOutput("t4 b_ready3", 64'(bus.b_ready), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4 a_ready A+B", 64'(bus.a_ready), 64'd1);
    checkOutput("t4 b_ready A+B", 64'(bus.b_ready), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0);
    bus.rd_addr1 = 5'd6;
    bus.rd_addr2 = 5'd2;
    @(negedge clk);
    checkOutput("t4 count full",   64'(bus.count),    64'd4);
    checkOutput("t4 a_ready full", 64'(bus.a_ready),  64'd0);
    checkOutput("t4 b_ready full", 64'(bus.b_ready),  64'd0);
    checkOutput("t4 hit1 full",    64'(bus.rd_data1), 64'h66);
    checkOutput("t4 hit2 full",    64'(bus.rd_data2), 64'h22);
    nextCycle();
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4 rf_we full",       64'(bus.rf_we),   64'd1);
    checkOutput("t4 no dequeue credit",64'(bus.a_ready), 64'd0);
    nextCycle();
    expQ.push_back({5'd9, 32'h99});
    @(negedge clk);
    checkOutput("t4 count after pop", 64'(bus.count),   64'd3);
    checkOutput("t4 a_ready after pop",64'(bus.a_ready), 64'd1);
    nextCycle();
    idle(1'b0);
    waitDrain("t4 drain count");

    // Register 0 writes are accepted but discarded
    nextCycle();
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t5 a_ready", 64'(bus.a_ready), 64'd1);
    nextCycle();
    idle(1'b0);
    bus.rd_addr1 = 5'd0;
    @(negedge clk);
    checkOutput("t5 count", 64'(bus.count),    64'd0);
    checkOutput("t5 rf_we", 64'(bus.rf_we),    64'd0);
    checkOutput("t5 hit1",  64'(bus.rd_hit1),  64'd0);
    checkOutput("t5 data1", 64'(bus.rd_data1), 64'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 32'h5555, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 1'b1);
    nextCycle();
    idle(1'b0);
    @(negedge clk);
    checkOutput("t5 B beside reg0", 64'(bus.rf_we), 64'd1);
    waitDrain("t5 drain count");

    // Async reset while entries are pending
    nextCycle();
    applyStimulus(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b1, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 5'd12, 32'hCC, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    nextCycle();
    idle(1'b1);
    bus.rd_addr1 = 5'd10;
    @(negedge clk);
    checkOutput("t6 count", 64'(bus.count),   64'd3);
    checkOutput("t6 hit1",  64'(bus.rd_hit1), 64'd1);
    @(posedge clk);
    #1 bus.hold = 1'b0;
    #1 checkOutput("t6 rf_we before reset", 64'(bus.rf_we), 64'd1);
    #1 rst = 1'b0;
    expQ.delete();
    #1;
    checkOutput("t6 rf_we in reset",   64'(bus.rf_we),   64'd0);
    checkOutput("t6 count in reset",   64'(bus.count),   64'd0);
    checkOutput("t6 hit1 in reset",    64'(bus.rd_hit1), 64'd0);
    checkOutput("t6 a_ready in reset", 64'(bus.a_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("t6 count after", 64'(bus.count), 64'd0);
    checkOutput("t6 rf_we after", 64'(bus.rf_we), 64'd0);

    checkOutput("leftover expected writes", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
